// File: rtl/strip_result_reader_if.sv
// Result stream from the strip reader toward frame re-assembly / host DMA.
interface strip_result_reader_if #(
    parameter int DATA_W = 23
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/strip_result_reader.sv
// Sweeps a conv strip unit's result BRAM after done and streams the words out in address order,
// hiding BRAM read latency and downstream backpressure behind a credit-controlled skid FIFO.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start; counters cleared
// WAIT_DONE | readout requested, waiting for unit_done level
// STREAM    | issuing BRAM reads and draining the FIFO downstream
// FINISH    | one-cycle done pulse after the last word was accepted
module strip_result_reader #(
    parameter int OUT_COUNT = 6216,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 23,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              unit_done,
    output logic [ADDR_W-1:0] strip_addr,
    input  logic [DATA_W-1:0] strip_data,
    output logic              busy,
    output logic              done,
    strip_result_reader_if.master m
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(OUT_COUNT + 1);
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = FCNT_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  issued_cnt;
    logic [CNT_W-1:0]  accept_cnt;
    logic [RD_LAT-1:0] tag;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occupancy;
    logic              valid;
    logic              last;
    logic              issue;
    logic              push;
    logic              pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(tag[i]);
        end
    end

    // A pop in the same cycle is not credited, so the FIFO can never overflow.
    assign occupancy = OCC_W'(fifo_count) + inflight;
    assign issue     = (state == ST_STREAM) && (issued_cnt < CNT_W'(OUT_COUNT)) &&
                       (occupancy < OCC_W'(FIFO_DEPTH));
    assign push      = tag[RD_LAT-1];
    assign valid     = (fifo_count != '0);
    assign last      = valid && (accept_cnt == CNT_W'(OUT_COUNT - 1));
    assign pop       = valid && m.m_ready;

    assign m.m_valid = valid;
    assign m.m_data  = valid ? mem[rd_ptr] : '0;
    assign m.m_last  = last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            strip_addr <= '0;
            issued_cnt <= '0;
            accept_cnt <= '0;
            tag        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (start) state <= ST_WAIT;
                ST_WAIT:   if (unit_done) state <= ST_STREAM;
                ST_STREAM: if (pop && last) state <= ST_FINISH;
                default:   state <= ST_IDLE;
            endcase

            if (state == ST_IDLE) begin
                issued_cnt <= '0;
                accept_cnt <= '0;
                strip_addr <= '0;
            end else if (issue) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
                strip_addr <= ADDR_W'(issued_cnt + CNT_W'(1));
            end

            // Tags mark cycles whose address will show up on strip_data RD_LAT cycles later.
            tag[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag[i] <= tag[i-1];
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                accept_cnt <= accept_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= strip_data;
        end
    end
endmodule

// File: tb/tb_strip_result_reader.sv
// Bench for strip_result_reader: full-size readouts under several ready patterns plus a small config.
module tb_strip_result_reader;
    localparam int OUT_COUNT = 6216;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 23;
    localparam int RD_LAT    = 2;
    localparam int DEPTH     = RD_LAT + 2;
    localparam int S_COUNT   = 5;
    localparam int S_ADDR_W  = 4;
    localparam int S_LAT     = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, unit_done = 1'b0, busy, done;
    logic [ADDR_W-1:0] strip_addr;
    logic [DATA_W-1:0] strip_data;
    logic start_s = 1'b0, unit_done_s = 1'b0, busy_s, done_s;
    logic [S_ADDR_W-1:0] strip_addr_s;
    logic [DATA_W-1:0]   strip_data_s;

    int n_assert = 0;
    int n_fail   = 0;

    strip_result_reader_if #(.DATA_W(DATA_W)) sif ();
    strip_result_reader_if #(.DATA_W(DATA_W)) sif_s ();

    strip_result_reader #(.OUT_COUNT(OUT_COUNT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .unit_done(unit_done),
        .strip_addr(strip_addr), .strip_data(strip_data), .busy(busy), .done(done), .m(sif));

    strip_result_reader #(.OUT_COUNT(S_COUNT), .ADDR_W(S_ADDR_W), .DATA_W(DATA_W), .RD_LAT(S_LAT)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .unit_done(unit_done_s),
        .strip_addr(strip_addr_s), .strip_data(strip_data_s), .busy(busy_s), .done(done_s), .m(sif_s));

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] f(input int a);
        return DATA_W'(a * 3 - 1000);
    endfunction

    // BRAM models: data reflects the address presented RD_LAT cycles earlier.
    logic [DATA_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= f(int'(strip_addr));
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign strip_data = bram_pipe[RD_LAT-1];

    logic [DATA_W-1:0] bram_s;
    always @(posedge clk) bram_s <= f(int'(strip_addr_s));
    assign strip_data_s = bram_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  64'(strip_addr), 64'd0);
        chk({tag, "_valid"}, 64'(sif.m_valid), 64'd0);
        chk({tag, "_data"},  64'(sif.m_data), 64'd0);
        chk({tag, "_last"},  64'(sif.m_last), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
    endtask

    // mode 0: ready=1, 1: random ready, 2: 20-cycle stall at word 3000, 3: reset at word 100
    task automatic run_stream(input int mode, input int wait_cycles);
        int acc = 0, cyc = 0, first_v = -1, last_acc = -1, stall_left = 0;
        int occ_bad = 0, hold_bad = 0, wait_bad = 0;
        bit stall_done = 0, prev_hold = 0, finished = 0, aborted = 0;
        logic [DATA_W-1:0] prev_data = '0;
        logic prev_last = 1'b0, rdy;
        logic [ADDR_W-1:0] frozen = '0;

        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_wait", 64'(busy), 64'd1);
        for (int i = 0; i < wait_cycles; i++) begin
            if (strip_addr !== '0 || sif.m_valid !== 1'b0 || busy !== 1'b1) wait_bad++;
            step();
        end
        if (wait_cycles > 0) chk("wait_done_hold", 64'(wait_bad), 64'd0);
        unit_done = 1'b1;
        step();

        while (!finished && !aborted && cyc < 40000) begin
            if (mode == 3 && acc == 100) begin
                reset = 1'b1;
                step();
                check_reset_outputs("rst_mid");
                reset = 1'b0;
                aborted = 1;
            end else begin
                start = (mode == 0 && cyc == 50);
                if (mode == 1) unit_done = 1'($urandom_range(0, 1));
                if (mode == 2 && acc == 3000 && !stall_done) begin
                    stall_left = 20;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                    if (stall_left == 10) frozen = strip_addr;
                    if (stall_left == 0) begin
                        chk("stall_addr_frozen", 64'(strip_addr), 64'(frozen));
                        chk("stall_outstanding", 64'(int'(strip_addr) - acc), 64'(DEPTH));
                    end
                end else if (mode == 1) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
                sif.m_ready = rdy;

                if (first_v < 0 && sif.m_valid === 1'b1) first_v = cyc;
                if (int'(strip_addr) < acc || int'(strip_addr) - acc > DEPTH) occ_bad++;
                if (prev_hold && (sif.m_valid !== 1'b1 || sif.m_data !== prev_data ||
                                  sif.m_last !== prev_last)) hold_bad++;
                if (sif.m_valid === 1'b1 && rdy) begin
                    chk($sformatf("word%0d", acc), 64'({sif.m_last, sif.m_data}),
                        64'({(acc == OUT_COUNT - 1), f(acc)}));
                    acc++;
                    last_acc = cyc;
                end
                prev_hold = (sif.m_valid === 1'b1) && !rdy;
                prev_data = sif.m_data;
                prev_last = sif.m_last;
                if (acc == OUT_COUNT) finished = 1;
                step();
                cyc++;
            end
        end
        start = 1'b0;

        chk("first_valid_latency", 64'(first_v), 64'(RD_LAT + 1));
        chk("outstanding_bound", 64'(occ_bad), 64'd0);
        chk("stall_stable", 64'(hold_bad), 64'd0);
        if (!aborted) begin
            chk("stream_complete", 64'(finished), 64'd1);
            chk("done_pulse", 64'({done, busy}), 64'b11);
            if (mode == 0) chk("no_bubbles", 64'(last_acc - first_v), 64'(OUT_COUNT - 1));
            if (mode == 2) chk("resume_no_gap", 64'(last_acc - first_v), 64'(OUT_COUNT - 1 + 20));
            step();
            chk("back_idle", 64'({done, busy, sif.m_valid}), 64'b000);
        end
        unit_done = 1'b0;
        sif.m_ready = 1'b1;
    endtask

    task automatic run_small();
        int acc = 0, first_v = -1, last_c = -1, done_c = -1, dones = 0;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        unit_done_s = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            if (first_v < 0 && sif_s.m_valid === 1'b1) first_v = c;
            if (done_s === 1'b1) begin
                dones++;
                done_c = c;
            end
            if (sif_s.m_valid === 1'b1) begin
                chk($sformatf("s_word%0d", acc), 64'({sif_s.m_last, sif_s.m_data}),
                    64'({(acc == S_COUNT - 1), f(acc)}));
                acc++;
                last_c = c;
            end
            step();
        end
        unit_done_s = 1'b0;
        chk("s_count", 64'(acc), 64'(S_COUNT));
        chk("s_first_valid", 64'(first_v), 64'(S_LAT + 1));
        chk("s_burst", 64'(last_c - first_v), 64'(S_COUNT - 1));
        chk("s_done_count", 64'(dones), 64'd1);
        chk("s_done_after_last", 64'(done_c), 64'(last_c + 1));
        chk("s_idle", 64'({busy_s, strip_addr_s}), 64'd0);
    endtask

    initial begin
        sif.m_ready   = 1'b1;
        sif_s.m_ready = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        check_reset_outputs("rst_init");
        reset = 1'b0;
        step();

        run_stream(0, 0);
        run_stream(1, 0);
        run_stream(2, 0);
        run_stream(0, 50);
        run_stream(3, 0);
        run_stream(0, 0);
        run_small();
        run_small();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
